fifo_lane: RTL and testbench

//  Per-lane synchronous FIFO placed directly downstream of the 1:2 demux; one instance per demux output lane.
//  - Buffers the 8-bit words the demux marks valid.
//  - Releases them in order on a pop request from the lane consumer.
//  - Reports full/empty/almost thresholds and overflow/underflow errors for flow control.

---
 rtl/fifo_lane.sv | 105 ++++++++++
 tb/tb_fifo_lane.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - per-lane 4-deep synchronous FIFO behind the 1:2 demux
// Define FIFO_ERR_STICKY_EN to hold fifo_error high from the first overflow/underflow until reset.
module fifo_lane #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 2,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  err_q, err_d;

  logic wr_ok, rd_ok, err_event;

  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign wr_ok     = valid_in && (!fifo_full || pop);
  assign rd_ok     = pop && !fifo_empty;
  assign err_event = (valid_in && fifo_full && !pop) || (pop && fifo_empty);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;

    if (wr_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      data_out_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
      valid_out_d = 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    err_d = err_q | err_event;
`else
    err_d = err_event;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      err_q       <= err_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign fifo_error = err_q;

endmodule

// File: tb/tb_fifo_lane.sv
// tb/tb_fifo_lane.sv - directed and random checks of fifo_lane against a queue model
// Honours FIFO_ERR_STICKY_EN the same way the design does.
module tb_fifo_lane;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       pop;
  logic [7:0] data_out;
  logic       valid_out, fifo_full, fifo_empty, almost_full, almost_empty, fifo_error;

  fifo_lane dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] q[$];
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":data_out"},     data_out,     exp_data);
    chk({tag, ":valid_out"},    {7'd0, valid_out},    {7'd0, exp_valid});
    chk({tag, ":fifo_full"},    {7'd0, fifo_full},    {7'd0, q.size() == 4});
    chk({tag, ":fifo_empty"},   {7'd0, fifo_empty},   {7'd0, q.size() == 0});
    chk({tag, ":almost_full"},  {7'd0, almost_full},  {7'd0, q.size() >= 3});
    chk({tag, ":almost_empty"}, {7'd0, almost_empty}, {7'd0, q.size() <= 1});
    chk({tag, ":fifo_error"},   {7'd0, fifo_error},   {7'd0, exp_err});
  endtask

  // One clock: present inputs at the falling edge, update the model at the rising edge, check 1ns later.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic p);
    bit full, empty, rd, wr, ev;
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    pop      = p;
    @(posedge clk);
    full  = (q.size() == 4);
    empty = (q.size() == 0);
    rd    = p && !empty;
    wr    = v && (!full || p);
    ev    = (v && full && !p) || (p && empty);
    if (rd) begin
      exp_data  = q.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (wr) q.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
    exp_err = exp_err | ev;
`else
    exp_err = ev;
`endif
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b0;
    pop      = 1'b0;
    q.delete();
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    #1;
    check_all({tag, ":async"});
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all({tag, ":released"});
  endtask

  initial begin
    reset = 1'b1;
    valid_in = 1'b0;
    pop = 1'b0;
    data_in = 8'h00;
    exp_data = 8'h00;
    exp_valid = 1'b0;
    exp_err = 1'b0;

    do_reset("t1_reset", 2);

    for (int i = 1; i <= 4; i++) step("t2_push", 1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++)  step("t2_pop", 1'b0, 8'h00, 1'b1);
    chk("t2_last_word", data_out, 8'hA4);

    for (int i = 1; i <= 4; i++) step("t3_fill", 1'b1, 8'(i), 1'b0);
    step("t3_overflow", 1'b1, 8'hFF, 1'b0);
    chk("t3_overflow_err", {7'd0, fifo_error}, 8'h01);
    for (int i = 0; i < 4; i++)  step("t3_drain", 1'b0, 8'h00, 1'b1);

    step("t5_underflow", 1'b0, 8'h00, 1'b1);
    chk("t5_underflow_err", {7'd0, fifo_error}, 8'h01);
    step("t5_idle", 1'b0, 8'h00, 1'b0);
    step("t5_empty_push_pop", 1'b1, 8'h77, 1'b1);
    step("t5_drain", 1'b0, 8'h00, 1'b1);

    do_reset("t4_reset", 1);
    for (int i = 1; i <= 4; i++) step("t4_fill", 1'b1, 8'(i), 1'b0);
    step("t4_full_push_pop", 1'b1, 8'h55, 1'b1);
    chk("t4_data", data_out, 8'h01);
    for (int i = 0; i < 4; i++)  step("t4_drain", 1'b0, 8'h00, 1'b1);
    chk("t4_last_word", data_out, 8'h55);

    step("t6_push", 1'b1, 8'h10, 1'b0);
    step("t6_push", 1'b1, 8'h20, 1'b0);
    do_reset("t6_reset", 1);
    step("t6_push", 1'b1, 8'h30, 1'b0);
    step("t6_pop", 1'b0, 8'h00, 1'b1);
    chk("t6_data", data_out, 8'h30);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_reset", 1);
      else step("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
